// File: rtl/lu_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lu_scan
//  Purpose  : Scans an 8x8 grid (x,y in 1..8), LU_BUS_SZ points per cycle,
//             flagging points inside a circle (cx,cy,r) for a downstream
//             hit accumulator. One scan = CLEAR (1) + SCAN (16) + DONE (1).
//  Ports    : clk_i        - clock, rising edge
//             rst_i        - asynchronous active-high reset
//             start_i      - start request, honoured only in IDLE
//             cx_i, cy_i   - circle centre (4-bit unsigned)
//             r_i          - circle radius (4-bit unsigned)
//             hit_o        - per-lane inside flags, valid with acc_en_o
//             acc_en_o     - accumulate hit_o this cycle
//             acc_clear_o  - clear the accumulator
//             busy_o       - scan in progress
//             done_o       - one-cycle completion pulse
//  Config   : LU_SCAN_OUT_REG_EN - when defined, hit_o/acc_en_o/acc_clear_o/
//             done_o pass through one output register stage (+1 cycle).
//  Revision : 1.0 - initial release
// ============================================================================
module lu_scan #(
    parameter int LU_BUS_SZ = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [3:0]           cx_i,
    input  logic [3:0]           cy_i,
    input  logic [3:0]           r_i,
    output logic [LU_BUS_SZ-1:0] hit_o,
    output logic                 acc_en_o,
    output logic                 acc_clear_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_CYCLE = 4'd15;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_c;
    logic [3:0]     r_cx;
    logic [3:0]     r_cy;
    logic [3:0]     r_r;

    logic                 w_acc_clear;
    logic                 w_acc_en;
    logic                 w_done;
    logic [LU_BUS_SZ-1:0] w_inside;
    logic [LU_BUS_SZ-1:0] w_hit;
    logic [9:0]           w_r_sq;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_clear = 1'b0;
        w_acc_en    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_acc_clear = 1'b1;
                w_state_nxt = SCAN;
            end
            SCAN: begin
                w_acc_en = 1'b1;
                if (r_c == c_LAST_CYCLE) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Parameters are captured once at start so mid-scan input changes are
    // invisible; the counter holds at 15 rather than wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cx <= 4'd0;
            r_cy <= 4'd0;
            r_r  <= 4'd0;
            r_c  <= 4'd0;
        end else begin
            if (r_state == IDLE && start_i) begin
                r_cx <= cx_i;
                r_cy <= cy_i;
                r_r  <= r_i;
            end
            if (r_state == CLEAR) begin
                r_c <= 4'd0;
            end else if (r_state == SCAN && r_c != c_LAST_CYCLE) begin
                r_c <= r_c + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Inside test per lane. Point index p = c*LU_BUS_SZ + k, so
    // x-1 = p[2:0] and y-1 = p[5:3]. Differences are taken in 6-bit two's
    // complement and squared as magnitudes in 10 bits (max 196+196=392).
    // ------------------------------------------------------------------------
    assign w_r_sq = 10'(r_r) * 10'(r_r);

    for (genvar k = 0; k < LU_BUS_SZ; k++) begin : g_lane
        logic [5:0] w_p;
        logic [3:0] w_x;
        logic [3:0] w_y;
        logic [5:0] w_dx;
        logic [5:0] w_dy;
        logic [5:0] w_ndx;
        logic [5:0] w_ndy;
        logic [4:0] w_adx;
        logic [4:0] w_ady;
        logic [9:0] w_d_sq;

        assign w_p    = 6'((int'(r_c) * LU_BUS_SZ) + k);
        assign w_x    = {1'b0, w_p[2:0]} + 4'd1;
        assign w_y    = {1'b0, w_p[5:3]} + 4'd1;
        assign w_dx   = {2'b00, w_x} - {2'b00, r_cx};
        assign w_dy   = {2'b00, w_y} - {2'b00, r_cy};
        assign w_ndx  = 6'd0 - w_dx;
        assign w_ndy  = 6'd0 - w_dy;
        assign w_adx  = w_dx[5] ? w_ndx[4:0] : w_dx[4:0];
        assign w_ady  = w_dy[5] ? w_ndy[4:0] : w_dy[4:0];
        assign w_d_sq = (10'(w_adx) * 10'(w_adx)) + (10'(w_ady) * 10'(w_ady));
        assign w_inside[k] = (w_d_sq <= w_r_sq);
    end

    assign w_hit = w_acc_en ? w_inside : '0;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
`ifdef LU_SCAN_OUT_REG_EN
    logic [LU_BUS_SZ-1:0] r_hit_q;
    logic                 r_acc_en_q;
    logic                 r_acc_clear_q;
    logic                 r_done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hit_q       <= '0;
            r_acc_en_q    <= 1'b0;
            r_acc_clear_q <= 1'b0;
            r_done_q      <= 1'b0;
        end else begin
            r_hit_q       <= w_hit;
            r_acc_en_q    <= w_acc_en;
            r_acc_clear_q <= w_acc_clear;
            r_done_q      <= w_done;
        end
    end

    assign hit_o       = r_hit_q;
    assign acc_en_o    = r_acc_en_q;
    assign acc_clear_o = r_acc_clear_q;
    assign done_o      = r_done_q;
    // Stretch busy over the delayed done pulse.
    assign busy_o      = (r_state != IDLE) | r_done_q;
`else
    assign hit_o       = w_hit;
    assign acc_en_o    = w_acc_en;
    assign acc_clear_o = w_acc_clear;
    assign done_o      = w_done;
    assign busy_o      = (r_state != IDLE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_lu_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lu_scan
//  Purpose  : Directed self-checking bench for lu_scan with a behavioural
//             downstream accumulator. Honours LU_SCAN_OUT_REG_EN (+1 cycle).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lu_scan;

`ifdef LU_SCAN_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [3:0] cx_i;
    logic [3:0] cy_i;
    logic [3:0] r_i;
    logic [3:0] hit_o;
    logic       acc_en_o;
    logic       acc_clear_o;
    logic       busy_o;
    logic       done_o;

    int checks   = 0;
    int failures = 0;
    int acc      = 0;

    always #5 clk_i = ~clk_i;

    lu_scan #(.LU_BUS_SZ(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .cx_i       (cx_i),
        .cy_i       (cy_i),
        .r_i        (r_i),
        .hit_o      (hit_o),
        .acc_en_o   (acc_en_o),
        .acc_clear_o(acc_clear_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Downstream accumulator as seen in the current cycle.
    task automatic acc_update;
        if (acc_clear_o) acc = 0;
        if (acc_en_o)    acc = acc + $countones(hit_o);
    endtask

    // One full scan. mode 0: only lane pattern chk_hit at cycle chk_c,
    // zero elsewhere; mode 1: 4'hF every scan cycle; mode 2: count only.
    task automatic run_scan(input logic [3:0] cx, input logic [3:0] cy,
                            input logic [3:0] r, input int exp_cnt,
                            input int mode, input int chk_c,
                            input logic [3:0] chk_hit, input string tag);
        logic [3:0] exp_ctrl;
        logic [3:0] exp_hit;
        int c;
        cx_i = cx; cy_i = cy; r_i = r; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cx_i = ~cx; cy_i = ~cy; r_i = ~r;   // must not disturb this scan
        acc = -1;
        for (int n = 1; n <= 19 + LAT; n++) begin
            exp_ctrl = {(n == 1 + LAT), (n >= 2 + LAT && n <= 17 + LAT),
                        (n == 18 + LAT), (n <= 18 + LAT)};
            c = n - 2 - LAT;
            exp_hit = 4'h0;
            if (exp_ctrl[2]) begin
                if (mode == 1) exp_hit = 4'hF;
                else if (mode == 0 && c == chk_c) exp_hit = chk_hit;
            end
            checks++;
            if ({acc_clear_o, acc_en_o, done_o, busy_o} !== exp_ctrl) begin
                failures++;
                $display("FAIL %s ctrl n=%0d got clr/en/done/busy=%b exp=%b",
                         tag, n, {acc_clear_o, acc_en_o, done_o, busy_o}, exp_ctrl);
            end
            if (mode != 2 || !exp_ctrl[2]) begin
                checks++;
                if (hit_o !== exp_hit) begin
                    failures++;
                    $display("FAIL %s hit n=%0d got=%b exp=%b", tag, n, hit_o, exp_hit);
                end
            end
            acc_update();
            if (exp_ctrl[1]) begin
                checks++;
                if (acc != exp_cnt) begin
                    failures++;
                    $display("FAIL %s count got=%0d exp=%0d", tag, acc, exp_cnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; start_i = 1'b0; cx_i = 4'd0; cy_i = 4'd0; r_i = 4'd0;
        tick();
        tick();
        checks++;
        if ({hit_o, acc_en_o, acc_clear_o, busy_o, done_o} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {hit_o, acc_en_o, acc_clear_o, busy_o, done_o}, 8'h00);
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy got=%b exp=0", busy_o);
        end
    endtask

    task automatic test_single_point;
        run_scan(4'd4, 4'd4, 4'd0, 1, 0, 6, 4'b1000, "c44_r0");
        run_scan(4'd8, 4'd1, 4'd0, 1, 0, 1, 4'b1000, "c81_r0");
    endtask

    task automatic test_corners;
        run_scan(4'd1, 4'd1, 4'd0, 1, 0, 0, 4'b0001, "c11_r0");
        run_scan(4'd8, 4'd8, 4'd0, 1, 0, 15, 4'b1000, "c88_r0");
        run_scan(4'd0, 4'd0, 4'd0, 0, 0, 0, 4'b0000, "c00_r0");
    endtask

    task automatic test_radius;
        run_scan(4'd4, 4'd4, 4'd15, 64, 1, 0, 4'b0000, "c44_r15");
        run_scan(4'd4, 4'd4, 4'd1, 5, 2, 0, 4'b0000, "c44_r1");
    endtask

    task automatic test_back_to_back;
        int clr_cnt;
        int done_cnt;
        int clr_n[2];
        int done_n[2];
        clr_cnt = 0; done_cnt = 0;
        clr_n[0] = 0; clr_n[1] = 0; done_n[0] = 0; done_n[1] = 0;
        cx_i = 4'd4; cy_i = 4'd4; r_i = 4'd0; start_i = 1'b1;
        tick();
        acc = -1;
        for (int n = 1; n <= 40 + LAT; n++) begin
            if (n == 5)  cx_i = 4'd9;
            if (n == 10) cx_i = 4'd4;
            if (n == 37) start_i = 1'b0;
            acc_update();
            if (acc_clear_o) begin
                if (clr_cnt < 2) clr_n[clr_cnt] = n;
                clr_cnt++;
            end
            if (done_o) begin
                if (done_cnt < 2) done_n[done_cnt] = n;
                done_cnt++;
                checks++;
                if (acc != 1) begin
                    failures++;
                    $display("FAIL b2b count n=%0d got=%0d exp=1", n, acc);
                end
            end
            tick();
        end
        start_i = 1'b0;
        checks++;
        if (clr_cnt != 2 || clr_n[0] != 1 + LAT || clr_n[1] != 20 + LAT) begin
            failures++;
            $display("FAIL b2b clear got cnt=%0d at %0d,%0d exp cnt=2 at %0d,%0d",
                     clr_cnt, clr_n[0], clr_n[1], 1 + LAT, 20 + LAT);
        end
        checks++;
        if (done_cnt != 2 || done_n[0] != 18 + LAT || done_n[1] != 37 + LAT) begin
            failures++;
            $display("FAIL b2b done got cnt=%0d at %0d,%0d exp cnt=2 at %0d,%0d",
                     done_cnt, done_n[0], done_n[1], 18 + LAT, 37 + LAT);
        end
    endtask

    task automatic test_reset_mid_scan;
        int bad;
        cx_i = 4'd4; cy_i = 4'd4; r_i = 4'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int n = 1; n < 9; n++) tick();   // SCAN c=7
        checks++;
        if (acc_en_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL midrst pre en/busy got=%b%b exp=11", acc_en_o, busy_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({hit_o, acc_en_o, acc_clear_o, busy_o, done_o} !== 8'h00) begin
            failures++;
            $display("FAIL midrst outputs got=%b exp=%b",
                     {hit_o, acc_en_o, acc_clear_o, busy_o, done_o}, 8'h00);
        end
        tick();
        rst_i = 1'b0;
        bad = 0;
        for (int n = 0; n < 25; n++) begin
            if (acc_en_o || done_o || busy_o) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midrst aftermath active_cycles got=%0d exp=0", bad);
        end
        // Start in the first cycle after rst deasserts.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        run_scan(4'd4, 4'd4, 4'd0, 1, 0, 6, 4'b1000, "post_rst");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_point();
        test_corners();
        test_radius();
        test_back_to_back();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
